edge_generator: RTL

EDGE_GENERATOR -- requirements
Module: edge_generator

---
 rtl/edge_generator_pkg.sv | 22 ++
 rtl/edge_generator_down_counter.sv | 36 +++
 rtl/edge_generator.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/edge_generator_pkg.sv
// ============================================================================
// Module  : edge_generator_pkg
// Brief   : State encodings and default widths shared by the edge generator.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package edge_generator_pkg;

    localparam int C_CNT_W_DEFAULT = 16;
    localparam int C_REP_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_HIGH  = 2'd2,
        ST_LOW   = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/edge_generator_down_counter.sv
// ============================================================================
// Module  : down_counter
// Brief   : Loadable down counter that holds at zero, with a zero flag.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module down_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] r_count;

    // Saturating at zero keeps a stray enable from wrapping into a huge period.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_count <= '0;
        end else if (load_i) begin
            r_count <= load_val_i;
        end else if (en_i && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign zero_o = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/edge_generator.sv
// ============================================================================
// Module  : edge_generator
// Brief   : Programmable pulse-train generator (delay, high, low, repeat).
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module edge_generator
    import edge_generator_pkg::*;
#(
    parameter int CNT_W = C_CNT_W_DEFAULT,
    parameter int REP_W = C_REP_W_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    output logic             ready_o,
    input  logic [CNT_W-1:0] delay_i,
    input  logic [CNT_W-1:0] high_i,
    input  logic [CNT_W-1:0] low_i,
    input  logic [REP_W-1:0] count_i,
    input  logic             abort_i,
    output logic             signal_o,
    output logic             rising_o,
    output logic             falling_o,
    output logic             busy_o,
    output logic             done_o
);

    state_t           r_state;
    logic [CNT_W-1:0] r_high_m1;
    logic [CNT_W-1:0] r_low_m1;
    logic [REP_W-1:0] r_pulses;
    logic             r_continuous;
    logic             r_signal;
    logic             r_rising;
    logic             r_falling;
    logic             r_busy;
    logic             r_done;
    logic             r_ready;

    logic             w_ld;
    logic             w_en;
    logic [CNT_W-1:0] w_ld_val;
    logic             w_zero;

    // Delay loads the raw value so DELAY lasts delay+1 cycles, matching the
    // one-cycle arming step a zero-delay train spends in HIGH before rising.
    always_comb begin
        w_ld     = 1'b0;
        w_en     = 1'b0;
        w_ld_val = '0;
        if (r_state == ST_IDLE) begin
            if (start_i) begin
                w_ld     = 1'b1;
                w_ld_val = delay_i;
            end
        end else if (!abort_i) begin
            case (r_state)
                ST_DELAY, ST_LOW: begin
                    if (w_zero) begin
                        w_ld     = 1'b1;
                        w_ld_val = r_high_m1;
                    end else begin
                        w_en = 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (!r_signal) begin
                        w_ld     = 1'b1;
                        w_ld_val = r_high_m1;
                    end else if (w_zero) begin
                        w_ld     = 1'b1;
                        w_ld_val = r_low_m1;
                    end else begin
                        w_en = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    down_counter #(
        .WIDTH (CNT_W)
    ) u_phase_cnt (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .load_i     (w_ld),
        .load_val_i (w_ld_val),
        .en_i       (w_en),
        .zero_o     (w_zero)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state      <= ST_IDLE;
            r_high_m1    <= '0;
            r_low_m1     <= '0;
            r_pulses     <= '0;
            r_continuous <= 1'b0;
            r_signal     <= 1'b0;
            r_rising     <= 1'b0;
            r_falling    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_ready      <= 1'b1;
        end else begin
            r_rising  <= 1'b0;
            r_falling <= 1'b0;
            r_done    <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (start_i) begin
                    r_high_m1    <= (high_i == '0) ? '0 : high_i - CNT_W'(1);
                    r_low_m1     <= (low_i == '0) ? '0 : low_i - CNT_W'(1);
                    r_pulses     <= count_i;
                    r_continuous <= (count_i == '0);
                    r_busy       <= 1'b1;
                    r_ready      <= 1'b0;
                    r_state      <= (delay_i != '0) ? ST_DELAY : ST_HIGH;
                end
            end else if (abort_i) begin
                r_state   <= ST_IDLE;
                r_signal  <= 1'b0;
                r_falling <= r_signal;
                r_done    <= 1'b1;
                r_busy    <= 1'b0;
                r_ready   <= 1'b1;
            end else begin
                case (r_state)
                    ST_DELAY, ST_LOW: begin
                        if (w_zero) begin
                            r_state  <= ST_HIGH;
                            r_signal <= 1'b1;
                            r_rising <= 1'b1;
                        end
                    end
                    ST_HIGH: begin
                        if (!r_signal) begin
                            r_signal <= 1'b1;
                            r_rising <= 1'b1;
                        end else if (w_zero) begin
                            r_signal  <= 1'b0;
                            r_falling <= 1'b1;
                            if (!r_continuous) begin
                                r_pulses <= r_pulses - REP_W'(1);
                            end
                            if (!r_continuous && (r_pulses == REP_W'(1))) begin
                                r_state <= ST_IDLE;
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                                r_ready <= 1'b1;
                            end else begin
                                r_state <= ST_LOW;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign signal_o  = r_signal;
    assign rising_o  = r_rising;
    assign falling_o = r_falling;
    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign ready_o   = r_ready;

endmodule

`default_nettype wire
